// File: rtl/jt49_noise_sync_if.sv
// Link between a JT49 noise generator (shift strobe plus serial bit)
// and the noise-stream checker that rebuilds and verifies its LFSR state.
interface jt49_noise_sync_if;
    logic        step;
    logic        noise_in;
    logic        locked;
    logic [16:0] state_out;
    logic        predict;
    logic        mismatch;
    logic [7:0]  err_cnt;

    modport master (
        output step, noise_in,
        input  locked, state_out, predict, mismatch, err_cnt
    );

    modport slave (
        input  step, noise_in,
        output locked, state_out, predict, mismatch, err_cnt
    );
endinterface

// File: rtl/jt49_noise_sync.sv
// Receiver for the AY-3-8910/YM2149 17-bit noise LFSR: rebuilds the generator
// state from the serial bit stream, predicts each next bit and tracks lock/errors.
module jt49_noise_sync #(
    parameter int unsigned CONFIRM = 8
) (
    input  logic             clk,
    input  logic             rst,
    jt49_noise_sync_if.slave bus
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [16:0] cap_q, cap_d;
    logic [4:0]  fill_q, fill_d;
    logic [7:0]  good_q, good_d;
    logic [7:0]  err_q, err_d;
    logic        locked_q;
    logic        mismatch_q, mismatch_d;
    logic        predict;
    logic        hit;
    logic [8:0]  goodInc;

    // An all-zero state still advances: the generator injects a 1 there.
    assign predict = cap_q[0] ^ cap_q[2] ^ (cap_q == 17'd0);
    assign hit     = (bus.noise_in == predict);
    assign goodInc = {1'b0, good_q} + 9'd1;

    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        fill_d     = fill_q;
        good_d     = good_q;
        err_d      = err_q;
        mismatch_d = 1'b0;

        if (bus.step) begin
            cap_d = {bus.noise_in, cap_q[16:1]};
            unique case (state_q)
                HUNT: begin
                    fill_d = fill_q + 5'd1;
                    if (fill_q == 5'd16) begin
                        state_d = VERIFY;
                        good_d  = 8'd0;
                    end
                end
                VERIFY: begin
                    if (hit) begin
                        good_d = goodInc[7:0];
                        if (goodInc == 9'(CONFIRM)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        mismatch_d = 1'b1;
                        fill_d     = 5'd0;
                        good_d     = 8'd0;
                        state_d    = HUNT;
                    end
                end
                LOCKED: begin
                    if (!hit) begin
                        mismatch_d = 1'b1;
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        fill_d  = 5'd0;
                        good_d  = 8'd0;
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            cap_q      <= 17'd0;
            fill_q     <= 5'd0;
            good_q     <= 8'd0;
            err_q      <= 8'd0;
            locked_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            fill_q     <= fill_d;
            good_q     <= good_d;
            err_q      <= err_d;
            locked_q   <= (state_d == LOCKED);
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.state_out = cap_q;
    assign bus.predict   = predict;
    assign bus.mismatch  = mismatch_q;
    assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_jt49_noise_sync.sv
// Bench for jt49_noise_sync: a fixed reset/fill table, hand-written lock and
// error sequences, and random streams scored against a bit-history model.
module tb_jt49_noise_sync;

    localparam int CONFIRM = 8;

    typedef struct {
        bit          rst;
        bit          st;
        bit          nb;
        logic [16:0] expState;
        bit          expPredict;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Model: the last 17 received bits (oldest first), steps since the last
    // resynchronisation, and the saturating error total.
    bit   hist[$];
    int   nSteps;
    int   modelErr;
    bit   modelMm;

    logic [16:0] genS;
    vec_t        vecs[20];

    jt49_noise_sync_if bus ();

    jt49_noise_sync #(.CONFIRM(CONFIRM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit modelPredict();
        bit allZero = 1'b1;
        foreach (hist[i]) if (hist[i]) allZero = 1'b0;
        return hist[0] ^ hist[2] ^ allZero;
    endfunction

    function automatic logic [16:0] modelState();
        logic [16:0] s;
        for (int i = 0; i < 17; i++) s[i] = hist[i];
        return s;
    endfunction

    task automatic modelUpdate(input bit r, input bit s, input bit b);
        bit p;
        modelMm = 1'b0;
        if (r) begin
            hist.delete();
            repeat (17) hist.push_back(1'b0);
            nSteps   = 0;
            modelErr = 0;
        end else if (s) begin
            p = modelPredict();
            if (nSteps >= 17 && b != p) begin
                modelMm = 1'b1;
                if (nSteps >= 17 + CONFIRM && modelErr < 255) modelErr++;
                nSteps = 0;
            end else begin
                nSteps++;
            end
            void'(hist.pop_front());
            hist.push_back(b);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput();
        checkValue("state_out", 32'(bus.state_out), 32'(modelState()));
        checkValue("predict", 32'(bus.predict), 32'(modelPredict()));
        checkValue("locked", 32'(bus.locked), 32'(nSteps >= 17 + CONFIRM));
        checkValue("mismatch", 32'(bus.mismatch), 32'(modelMm));
        checkValue("err_cnt", 32'(bus.err_cnt), 32'(modelErr));
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit b);
        rst          = r;
        bus.step     = s;
        bus.noise_in = b;
        @(posedge clk);
        modelUpdate(r, s, b);
        #1;
        checkOutput();
        rst      = 1'b0;
        bus.step = 1'b0;
    endtask

    // Reference generator: next = {s0^s2^(s==0), s[16:1]}, emitting the new top bit.
    task automatic genBit(output bit b);
        b    = genS[0] ^ genS[2] ^ (genS == 17'd0);
        genS = {b, genS[16:1]};
    endtask

    task automatic sendStep(input bit flip);
        bit b;
        genBit(b);
        applyStimulus(1'b0, 1'b1, b ^ flip);
    endtask

    task automatic resetAll();
        applyStimulus(1'b1, 1'b0, 1'b0);
        genS = 17'd0;
    endtask

    initial begin
        bit dummy;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.step     = 1'b0;
        bus.noise_in = 1'b0;
        genS         = 17'd0;
        modelUpdate(1'b1, 1'b0, 1'b0);

        vecs[0] = '{1'b1, 1'b0, 1'b0, 17'h00000, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 17'h00000, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 17'h00000, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 17'h10000, 1'b0};
        for (int j = 1; j <= 14; j++)
            vecs[3 + j] = '{1'b0, 1'b1, 1'b0, 17'h10000 >> j, j == 14};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 17'h10002, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b0, 17'h08001, 1'b1};

        // Reset, reset-with-step, zero-state release, then the first 17 generator bits.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].nb);
            if (vecs[i].rst) genS = 17'd0;
            else if (vecs[i].st) genBit(dummy);
            checkValue($sformatf("tbl%0d_state", i), 32'(bus.state_out), 32'(vecs[i].expState));
            checkValue($sformatf("tbl%0d_predict", i), 32'(bus.predict), 32'(vecs[i].expPredict));
        end

        // Reset lock: steps 18..25 every 3 clocks, lock right after step 25.
        for (int k = 18; k <= 25; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
            sendStep(1'b0);
            if (k == 24) checkValue("lock_before25", 32'(bus.locked), 32'd0);
            if (k == 25) checkValue("lock_at25", 32'(bus.locked), 32'd1);
        end

        // Bit flip while locked, then relock after 17+8 clean steps.
        sendStep(1'b1);
        checkValue("flip_mismatch", 32'(bus.mismatch), 32'd1);
        checkValue("flip_err", 32'(bus.err_cnt), 32'd1);
        checkValue("flip_unlock", 32'(bus.locked), 32'd0);
        for (int k = 1; k <= 25; k++) begin
            sendStep(1'b0);
            if (k == 24) checkValue("relock_early", 32'(bus.locked), 32'd0);
        end
        checkValue("relock", 32'(bus.locked), 32'd1);
        checkValue("relock_err", 32'(bus.err_cnt), 32'd1);

        // Reset collision while locked: the step is discarded.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkValue("coll_state", 32'(bus.state_out), 32'd0);
        checkValue("coll_predict", 32'(bus.predict), 32'd1);
        checkValue("coll_locked", 32'(bus.locked), 32'd0);
        checkValue("coll_err", 32'(bus.err_cnt), 32'd0);
        genS = 17'd0;

        // Bit flip during VERIFY at step 20: lock first rises at step 45.
        for (int k = 1; k <= 45; k++) begin
            sendStep(k == 20);
            if (k == 20) begin
                checkValue("verify_mismatch", 32'(bus.mismatch), 32'd1);
                checkValue("verify_err", 32'(bus.err_cnt), 32'd0);
            end
            if (k == 44) checkValue("verify_lock44", 32'(bus.locked), 32'd0);
        end
        checkValue("verify_lock45", 32'(bus.locked), 32'd1);

        // Random strobe spacing with occasional corrupted bits.
        resetAll();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(1, 0) == 1) sendStep($urandom_range(79, 0) == 0);
            else applyStimulus(1'b0, 1'b0, 1'b0);
        end

        // Pure random bits, including occasional mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(199, 0) == 0) resetAll();
            else applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        // Saturation: 300 misses while locked, relocking in between.
        resetAll();
        repeat (25) sendStep(1'b0);
        for (int m = 0; m < 300; m++) begin
            sendStep(1'b1);
            repeat (25) sendStep(1'b0);
        end
        checkValue("sat_err", 32'(bus.err_cnt), 32'd255);
        checkValue("sat_locked", 32'(bus.locked), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jt49_noise_sync.md
# jt49_noise_sync

Noise-stream receiver and checker for the AY-3-8910/YM2149 17-bit noise LFSR. It observes the serial noise bit together with the generator's shift strobe and reconstructs the full LFSR state. It then predicts each following bit and reports lock, mismatches and an error count. It sits beside the PSG core as the receiving end of the noise generator's output, for self-check and for cycle-exact alignment of an external model.

## Interface
- `CONFIRM`, default 8: number of consecutive correct predictions (1..255) needed after the state fill before `locked` asserts.
- `clk`  in  1  system clock, the same divided clock that drives the PSG core.
- `rst`  in  1  synchronous reset, active-high.
- `step`  in  1  one-cycle strobe, asserted in the cycle where the generator's LFSR shifts (its `cen && noise_en`).
- `noise_in`  in  1  generator output bit after that shift. Sampled on the rising edge where `step`=1.
- `locked`  out  1  reconstructed state is trusted.
- `state_out`  out  17  reconstructed LFSR state, same bit order as the generator.
- `predict`  out  1  expected value of the next `noise_in` bit.
- `mismatch`  out  1  one-cycle pulse: a compared bit differed from the prediction.
- `err_cnt`  out  8  mismatches counted while `locked`, saturating at 255.

## Operation
- Generator model: `next = {s[0]^s[2]^(s==0), s[16:1]}`, output `= s[16]`. Each emitted bit is the feedback bit that enters `s[16]`.
- Capture register `cap`, 17 bits. On every `step`: `cap <= {noise_in, cap[16:1]}`, in all states. After 17 steps `cap` equals the generator state exactly.
- `state_out = cap`. `predict = cap[0]^cap[2]^(cap==17'd0)` is combinational from `cap`.
- Compare: on a `step` in VERIFY or LOCKED, `hit = (noise_in == predict)`, evaluated before `cap` updates.
- States:
  - **HUNT**:
    - `fill` counter (5 bits) increments per `step`.
    - When `fill` reaches 17 (on the 17th step), go to VERIFY with `good`=0.
    - No comparisons in this state.
  - **VERIFY**:
    - Hit: `good`++. On the step where `good` reaches `CONFIRM`, go to LOCKED.
    - Miss: pulse `mismatch`, clear `fill` and `good`, go to HUNT. `err_cnt` is unchanged.
  - **LOCKED**:
    - Hit: no action.
    - Miss: pulse `mismatch`, increment `err_cnt` (saturating), clear `fill`, go to HUNT.
- `locked` = (state == LOCKED), registered.
- An all-zero `cap` is legal (the generator reset state). The prediction then is 1.
- `err_cnt` is cleared only by `rst`. It does not clear on relock.
- `step`=0: no register changes except reset.

## Timing
- Reset values: `cap`=0, `fill`=0, `good`=0, state=HUNT, `locked`=0, `mismatch`=0, `err_cnt`=0. Consequently `state_out`=0 and `predict`=1.
- `rst` wins over a simultaneous `step`; that step is discarded. A reset mid-fill or while LOCKED returns to HUNT with `fill`=0.
- `cap`, `state_out` and `predict` update the cycle after the sampling edge (one-cycle latency).
- `mismatch` is high for exactly the one cycle following the offending `step` edge. `err_cnt` updates on that same edge.
- `locked` rises on the cycle after the `CONFIRM`-th hit. Minimum lock time after reset is 17+`CONFIRM` steps.
- `locked` falls on the cycle after a miss.
- Back-to-back `step` on every clock is supported, with no throughput limit.
- `fill` saturates behaviour: the transition fires exactly at 17, and the counter never wraps.

## Test plan
- **Reset lock:** generator and checker reset together, `step` every 3 clocks, `CONFIRM`=8. Required response:
  - First 16 bits are 1, 0×14, 1.
  - After 17 steps `state_out`=17'h08001.
  - `locked` rises after step 25.
  - `mismatch` is never asserted.
- **Zero state:** hold checker in reset, release with `cap`=0. The first prediction is 1; drive `noise_in`=1 and require no mismatch.
- **Bit flip while locked:** after lock, invert one `noise_in` bit. Required response:
  - One `mismatch` pulse; `err_cnt`=1; `locked`=0 on the next cycle.
  - Relock after 17+8 clean steps.
  - `err_cnt` stays at 1.
- **Bit flip during VERIFY:** invert the bit at step 20. Required response:
  - `mismatch` pulses and `err_cnt` stays 0.
  - `locked` first rises at step 20+17+8=45.
- **Saturation:** force 300 misses while locked, relocking between each. `err_cnt` ends at 255.
- **Reset collision:** assert `rst` together with `step` while LOCKED. Required response:
  - All outputs return to their reset values the next cycle.
  - `cap` is 0 and ignores that step's `noise_in`.
